// File: rtl/brainfuck_jumptable_builder.sv
// Pre-run sequencer for brainfuck_cpu. It scans program memory and matches '['/']'
// pairs with an internal stack. It fills the jump-pointer table that the CPU reads
// through jumpptr_addr, and it holds the CPU in reset until that table is valid.
//
// Optional feature: define JUMPTABLE_CLEAR_EN to zero the whole jump table before
// the scan. This costs 2^INST_ADDR_WIDTH extra cycles.
//
// Ports:
//   clk             rising-edge clock
//   rst_i           synchronous active-high reset
//   start           1-cycle build request; honoured only in IDLE/DONE/ERR
//   prog_size       program length in bytes (IAW+1 bits), sampled on start
//   inst_addr       program memory read address (sync RAM, 1-cycle latency)
//   inst_load_data  program byte for the address presented last cycle
//   jt_addr         jump-table write address
//   jt_store_data   jump-table write data
//   jt_we           jump-table write enable
//   busy            build in progress
//   done            table valid; held until start or rst_i
//   error           bracket error; held until start or rst_i
//   error_code      01 unmatched ']', 10 unmatched '[', 11 stack overflow
//   error_addr      address of the offending bracket
//   cpu_rst_n       active-low CPU reset; high only in DONE
module brainfuck_jumptable_builder #(
  parameter int unsigned INST_ADDR_WIDTH = 15,
  parameter int unsigned STACK_DEPTH     = 64,
  parameter int unsigned STACK_PTR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH:0]   prog_size,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr,
  input  logic [7:0]                 inst_load_data,
  output logic [INST_ADDR_WIDTH-1:0] jt_addr,
  output logic [INST_ADDR_WIDTH-1:0] jt_store_data,
  output logic                       jt_we,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 error_code,
  output logic [INST_ADDR_WIDTH-1:0] error_addr,
  output logic                       cpu_rst_n
);

  localparam int unsigned IAW    = INST_ADDR_WIDTH;
  localparam int unsigned SIZE_W = INST_ADDR_WIDTH + 1;
  localparam int unsigned SP_W   = STACK_PTR_WIDTH + 1;

  localparam logic [SIZE_W-1:0] PROG_MAX  = SIZE_W'(1) << INST_ADDR_WIDTH;
  localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
  localparam logic [7:0]        CH_OPEN   = 8'h5B;
  localparam logic [7:0]        CH_CLOSE  = 8'h5D;
  localparam logic [1:0]        ERR_CLOSE = 2'b01;
  localparam logic [1:0]        ERR_OPEN  = 2'b10;
  localparam logic [1:0]        ERR_OVF   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PRIME, S_SCAN, S_PAIR, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] scan_q, scan_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IAW-1:0]    pair_q, pair_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [IAW-1:0]    err_addr_q, err_addr_d;
  logic [IAW-1:0]    stack_q [STACK_DEPTH];
  logic              push_c;

  logic              is_open_c, is_close_c, last_c, empty_c;
  logic [IAW-1:0]    tos_c;

  // Byte decode and scan bookkeeping shared by both combinational processes.
  assign is_open_c  = (inst_load_data == CH_OPEN);
  assign is_close_c = (inst_load_data == CH_CLOSE);
  assign last_c     = ((scan_q + SIZE_W'(1)) == size_q);
  assign empty_c    = (sp_q == '0);
  assign tos_c      = stack_q[STACK_PTR_WIDTH'(sp_q - SP_W'(1))];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      scan_q     <= '0;
      sp_q       <= '0;
      pair_q     <= '0;
      err_code_q <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      scan_q     <= scan_d;
      sp_q       <= sp_d;
      pair_q     <= pair_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Bracket stack storage; contents need no reset because sp_q gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      stack_q[sp_q[STACK_PTR_WIDTH-1:0]] <= IAW'(scan_q);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    scan_d     = scan_q;
    sp_d       = sp_q;
    pair_d     = pair_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    push_c     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          size_d     = (prog_size > PROG_MAX) ? PROG_MAX : prog_size;
          scan_d     = '0;
          sp_d       = '0;
          err_code_d = '0;
          err_addr_d = '0;
`ifdef JUMPTABLE_CLEAR_EN
          state_d    = S_CLEAR;
`else
          state_d    = S_PRIME;
`endif
        end
      end

`ifdef JUMPTABLE_CLEAR_EN
      // scan_q doubles as the clear address; it is rewound before PRIME.
      S_CLEAR: begin
        if (scan_q == (PROG_MAX - SIZE_W'(1))) begin
          scan_d  = '0;
          state_d = S_PRIME;
        end else begin
          scan_d = scan_q + SIZE_W'(1);
        end
      end
`endif

      S_PRIME: begin
        state_d = (size_q == '0) ? S_DONE : S_SCAN;
      end

      S_SCAN: begin
        if (is_open_c) begin
          if (sp_q == SP_FULL) begin
            state_d    = S_ERR;
            err_code_d = ERR_OVF;
            err_addr_d = IAW'(scan_q);
          end else if (last_c) begin
            // A '[' as the final byte can never be closed.
            state_d    = S_ERR;
            err_code_d = ERR_OPEN;
            err_addr_d = IAW'(scan_q);
          end else begin
            push_c = 1'b1;
            sp_d   = sp_q + SP_W'(1);
            scan_d = scan_q + SIZE_W'(1);
          end
        end else if (is_close_c) begin
          if (empty_c) begin
            state_d    = S_ERR;
            err_code_d = ERR_CLOSE;
            err_addr_d = IAW'(scan_q);
          end else begin
            sp_d    = sp_q - SP_W'(1);
            pair_d  = tos_c;
            state_d = S_PAIR;
          end
        end else if (last_c) begin
          if (empty_c) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = ERR_OPEN;
            err_addr_d = tos_c;
          end
        end else begin
          scan_d = scan_q + SIZE_W'(1);
        end
      end

      // The stack has already been popped, so the end-of-program test sees the new depth.
      S_PAIR: begin
        if (last_c) begin
          if (empty_c) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = ERR_OPEN;
            err_addr_d = tos_c;
          end
        end else begin
          scan_d  = scan_q + SIZE_W'(1);
          state_d = S_SCAN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    inst_addr     = '0;
    jt_addr       = '0;
    jt_store_data = '0;
    jt_we         = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    cpu_rst_n     = 1'b0;

    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
`ifdef JUMPTABLE_CLEAR_EN
      S_CLEAR: begin
        jt_we   = 1'b1;
        jt_addr = IAW'(scan_q);
      end
`endif
      S_PRIME: inst_addr = '0;
      // ']' entry points just past its matching '['.
      S_SCAN: begin
        inst_addr = IAW'(scan_q + SIZE_W'(1));
        if (is_close_c && !empty_c) begin
          jt_we         = 1'b1;
          jt_addr       = IAW'(scan_q);
          jt_store_data = tos_c + IAW'(1);
        end
      end
      // '[' entry points at its matching ']', so the last address never wraps.
      S_PAIR: begin
        inst_addr     = IAW'(scan_q + SIZE_W'(1));
        jt_we         = 1'b1;
        jt_addr       = pair_q;
        jt_store_data = IAW'(scan_q);
      end
      default: busy = 1'b1;
    endcase
  end

  assign error_code = err_code_q;
  assign error_addr = err_addr_q;

endmodule

// File: tb/tb_brainfuck_jumptable_builder.sv
// Self-checking bench for brainfuck_jumptable_builder. A software bracket matcher
// predicts every jump-table write into a scoreboard queue, and a negedge monitor
// pops and compares each write the DUT makes. Final status is checked per build.
module tb_brainfuck_jumptable_builder;

  localparam int unsigned IAW   = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPW   = 2;
  localparam int unsigned MEM   = 1 << IAW;
`ifdef JUMPTABLE_CLEAR_EN
  localparam int unsigned CLR   = MEM;
`else
  localparam int unsigned CLR   = 0;
`endif

  typedef struct packed {
    logic [IAW-1:0] addr;
    logic [IAW-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           start;
  logic [IAW:0]   prog_size;
  logic [IAW-1:0] inst_addr;
  logic [7:0]     inst_load_data;
  logic [IAW-1:0] jt_addr;
  logic [IAW-1:0] jt_store_data;
  logic           jt_we;
  logic           busy;
  logic           done;
  logic           error;
  logic [1:0]     error_code;
  logic [IAW-1:0] error_addr;
  logic           cpu_rst_n;

  logic [7:0] pmem [MEM];
  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  brainfuck_jumptable_builder #(
    .INST_ADDR_WIDTH(IAW),
    .STACK_DEPTH    (DEPTH),
    .STACK_PTR_WIDTH(SPW)
  ) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .start         (start),
    .prog_size     (prog_size),
    .inst_addr     (inst_addr),
    .inst_load_data(inst_load_data),
    .jt_addr       (jt_addr),
    .jt_store_data (jt_store_data),
    .jt_we         (jt_we),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .error_code    (error_code),
    .error_addr    (error_addr),
    .cpu_rst_n     (cpu_rst_n)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory.
  always @(posedge clk) inst_load_data <= pmem[inst_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer for every jump-table write.
  always @(negedge clk) begin
    if (jt_we) begin
      if (exp_q.size() == 0) begin
        check("jt_unexpected_write", 32'(jt_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("jt_addr", 32'(jt_addr), 32'(e.addr));
        check("jt_data", 32'(jt_store_data), 32'(e.data));
      end
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < MEM; i++) pmem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) pmem[i] = s[i];
    prog_size = (IAW+1)'(s.len());
  endtask

  // Reference bracket matcher: pushes expected writes, returns expected status.
  task automatic model(input int n, output logic [1:0] code, output logic [IAW-1:0] eaddr,
                       output int pairs);
    int  stk[$];
    int  i;
    wr_t w;
    code = 2'b00; eaddr = '0; pairs = 0;
    for (int a = 0; a < int'(CLR); a++) begin
      w.addr = IAW'(a); w.data = '0; exp_q.push_back(w);
    end
    for (int k = 0; k < n; k++) begin
      if (pmem[k] == "[") begin
        if (stk.size() == int'(DEPTH)) begin
          code = 2'b11; eaddr = IAW'(k); return;
        end
        stk.push_back(k);
      end else if (pmem[k] == "]") begin
        if (stk.size() == 0) begin
          code = 2'b01; eaddr = IAW'(k); return;
        end
        i = stk.pop_back();
        w.addr = IAW'(k); w.data = IAW'(i + 1); exp_q.push_back(w);
        w.addr = IAW'(i); w.data = IAW'(k);     exp_q.push_back(w);
        pairs++;
      end
    end
    if (stk.size() != 0) begin
      code = 2'b10; eaddr = IAW'(stk[$]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_case(input string name, input int n, input bit inject);
    logic [1:0]     code;
    logic [IAW-1:0] eaddr;
    int             pairs;
    int             cyc;
    model(n, code, eaddr, pairs);
    pulse_start();
    cyc = 0;
    while (!(done || error) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = inject && (cyc == 3);
    end
    start = 1'b0;
    check({name, "_timeout"}, 32'(cyc < 2000), 32'd1);
    check({name, "_done"}, 32'(done), 32'(code == 2'b00));
    check({name, "_error"}, 32'(error), 32'(code != 2'b00));
    check({name, "_code"}, 32'(error_code), 32'(code));
    check({name, "_eaddr"}, 32'(error_addr), 32'(eaddr));
    check({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(code == 2'b00));
    check({name, "_busy"}, 32'(busy), 32'd0);
    if (code == 2'b00) check({name, "_cycles"}, 32'(cyc), 32'(n + pairs + 1 + int'(CLR)));
    check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_i = 1'b1; start = 1'b0; prog_size = '0;
    load("");
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_code", 32'(error_code), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_jt_we", 32'(jt_we), 32'd0);
    rst_i = 1'b0;

    load("+[->+<]."); run_case("simple_loop", 8, 1'b0);
    load("[[]][]");   run_case("nested_busy_start", 6, 1'b1);
    load("+]");       run_case("stray_close", 2, 1'b0);
    load("[[+]");     run_case("open_left", 4, 1'b0);
    load("[[[[[");    run_case("overflow", 5, 1'b0);
    load("[]+[");     run_case("last_open", 4, 1'b0);

    // Abort a build with rst_i, then rebuild from IDLE.
    load("+[->+<].");
    pulse_start();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_jt_we", 32'(jt_we), 32'd0);
    check("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst_i = 1'b0;
    exp_q.delete();
    run_case("after_abort", 8, 1'b0);

    load("");
    run_case("empty_prog", 0, 1'b0);

    // Oversized prog_size clamps to the full address space; the pair spans it.
    load("");
    for (int i = 0; i < MEM; i++) pmem[i] = "+";
    pmem[0]       = "[";
    pmem[MEM-1]   = "]";
    prog_size     = (IAW+1)'(100);
    run_case("clamped_full", int'(MEM), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
